// File: rtl/bank_demux.sv
// -----------------------------------------------------------------------------
// bank_demux
//
// Write-side row distributor. Rows arriving over a valid/ready handshake are
// spread round-robin over POY line-buffer banks, bank index fastest: row k of
// a fill goes to bank (k mod POY) at address (k div POY). Every accepted row
// produces one registered write (one-hot strobe, address, data, bank index)
// in the cycle after it was accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse: latch cfg_rows, clear counters, begin a fill
//   cfg_rows   rows per bank for the fill (clamped to DEPTH when latched)
//   in_valid   in_data holds a valid row
//   in_ready   high while filling; a row is taken when in_valid && in_ready
//   in_data    incoming row, BUFW elements of DW bits
//   bank_we    one-hot bank write strobe (registered)
//   bank_addr  row address inside the selected bank (registered)
//   bank_wdata row data (registered)
//   wr_bank    index of the bank selected by bank_we (registered)
//   busy       high while filling
//   done       one-cycle pulse when a fill completes
// -----------------------------------------------------------------------------
module bank_demux #(
  parameter int DW    = 1,
  parameter int POY   = 3,
  parameter int BUFW  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                cfg_rows,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUFW-1:0][DW-1:0]   in_data,
  output logic [POY-1:0]            bank_we,
  output logic [AW-1:0]             bank_addr,
  output logic [BUFW-1:0][DW-1:0]   bank_wdata,
  output logic [7:0]                wr_bank,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [8:0] DEPTH9   = 9'(DEPTH);
  localparam logic [7:0] LAST_BNK = 8'(POY - 1);

  state_t         state_reg, state_next;
  logic [7:0]     rows_reg, rows_next;
  logic [7:0]     bank_reg, bank_next;
  logic [AW-1:0]  addr_reg, addr_next;

  logic           accept;
  logic           last_row;
  logic [7:0]     rows_clamped;
  logic [POY-1:0] we_onehot;

  assign accept   = in_valid && (state_reg == FILL);
  assign in_ready = (state_reg == FILL);
  assign busy     = (state_reg == FILL);
  assign done     = (state_reg == DONE);

  // DEPTH fits in 9 bits; cfg_rows can never exceed 255, so when DEPTH is 256
  // the clamp is simply never taken.
  assign rows_clamped = ({1'b0, cfg_rows} > DEPTH9) ? DEPTH9[7:0] : cfg_rows;

  // Final row of the fill: last bank of the last address (rows_reg >= 1 here).
  assign last_row = (bank_reg == LAST_BNK) &&
                    ((9'(addr_reg) + 9'd1) == {1'b0, rows_reg});

  // One-hot strobe for the bank currently being written.
  generate
    for (genvar gi = 0; gi < POY; gi++) begin : g_we
      assign we_onehot[gi] = accept && (bank_reg == 8'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    rows_next  = rows_reg;
    bank_next  = bank_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          rows_next  = rows_clamped;
          bank_next  = '0;
          addr_next  = '0;
          state_next = (rows_clamped == 8'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        // A restart wins over the counter advance; a row accepted in the same
        // cycle is still written at its old position by the output registers.
        if (start) begin
          rows_next  = rows_clamped;
          bank_next  = '0;
          addr_next  = '0;
          state_next = (rows_clamped == 8'd0) ? DONE : FILL;
        end else if (accept) begin
          if (bank_reg == LAST_BNK) begin
            bank_next = '0;
            addr_next = addr_reg + AW'(1);
          end else begin
            bank_next = bank_reg + 8'd1;
          end
          if (last_row) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rows_reg  <= '0;
      bank_reg  <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rows_reg  <= rows_next;
      bank_reg  <= bank_next;
      addr_reg  <= addr_next;
    end
  end

  // Write port registers: the strobe lasts one cycle per accept, the
  // address/data/index hold their last values between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      wr_bank    <= '0;
    end else begin
      bank_we <= we_onehot;
      if (accept) begin
        bank_addr  <= addr_reg;
        bank_wdata <= in_data;
        wr_bank    <= bank_reg;
      end
    end
  end

endmodule

// File: doc/bank_demux.md
# bank_demux

Write-side counterpart of the data-router bank mux. It accepts a stream of BUFW-wide rows over a valid/ready handshake and distributes them round-robin across POY line-buffer banks. Each row gets a registered per-bank write strobe and a row address. Downstream, the bank mux reads those banks back using the same 8-bit bank index.

## Interface
Parameters:
- DW, 1, width of one data element
- POY, 3, number of banks (max 256; 8-bit bank index)
- BUFW, 32, elements per row
- DEPTH, 16, rows per bank; AW = $clog2(DEPTH) (min 1)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches cfg_rows and begins a fill
- cfg_rows  input  8  rows to write per bank (valid 0..DEPTH)
- in_valid  input  1  in_data holds a valid row
- in_ready  output  1  block accepts a row this cycle
- in_data  input  DW x [BUFW]  incoming row
- bank_we  output  POY  one-hot write strobe, registered
- bank_addr  output  AW  row address within the selected bank, registered
- bank_wdata  output  DW x [BUFW]  row data, registered
- wr_bank  output  8  index of the bank that bank_we selects, registered
- busy  output  1  high in FILL
- done  output  1  one-cycle pulse when a fill completes

## Operation
- States are IDLE, FILL and DONE. Reset enters IDLE.
- IDLE:
  - in_ready=0.
  - start=1: latch cfg_rows into rows_q, clear cur_bank and cur_addr.
  - Then go to FILL, or to DONE if cfg_rows==0.
- FILL:
  - in_ready=1. A row is accepted when in_valid && in_ready.
  - On accept:
    - register in_data into bank_wdata.
    - set bank_we[cur_bank]=1, bank_addr=cur_addr, wr_bank=cur_bank.
  - Advance:
    - If cur_bank==POY-1: cur_bank wraps to 0 and cur_addr increments.
    - Otherwise cur_bank increments.
  - Last accepted row is cur_bank==POY-1 && cur_addr==rows_q-1. On that accept go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. in_ready=0.
- Fill order is bank-fastest: row k goes to bank k mod POY, address k div POY.
- Total rows per fill = rows_q*POY.
- cfg_rows>DEPTH is clamped to DEPTH at latch time.
- start during FILL restarts the fill:
  - relatch cfg_rows, clear counters.
  - A row accepted in the same cycle is still written at the old position.
- start during DONE is ignored.
- Cycles with no accept leave bank_we=0. bank_addr, bank_wdata and wr_bank hold their last values.
- busy = (state==FILL).

## Timing
- Reset values:
  - in_ready=0, bank_we=0, bank_addr=0, bank_wdata all 0, wr_bank=0, busy=0, done=0.
  - State is IDLE and counters are 0.
- start sampled at edge N puts in_ready=1 from cycle N+1.
- Accept at edge M: bank_we, bank_addr, bank_wdata and wr_bank are valid in cycle M+1 for one cycle.
- Back-to-back accepts give one write per cycle with no bubbles.
- Last row accepted at edge L:
  - write strobe in cycle L+1, done=1 in cycle L+1.
  - in_ready=0 from cycle L+1, IDLE in cycle L+2.
- cfg_rows==0: done pulses the cycle after start; no writes occur.
- in_valid deasserted mid-fill stalls the counters; there is no timeout.
- Reset asserted mid-fill:
  - all outputs go immediately to reset values, including any pending bank_we.
  - No partial write is issued after rst_n rises.

## Test plan
- POY=3, cfg_rows=2, six consecutive valid rows with data=k -> writes go to (bank,addr) (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on consecutive cycles; done pulses with the 6th write.
- Same config, in_valid toggled every other cycle -> same six (bank,addr) pairs, each written exactly once; total 6 bank_we pulses.
- cfg_rows=0 -> done one cycle after start; bank_we never asserts; in_ready stays 0.
- cfg_rows=200, DEPTH=16 -> exactly 48 writes; last write bank 2, addr 15.
- start pulsed after 4 accepts of a cfg_rows=2 fill -> 4th row written at (0,1); next row at (0,0); 6 further writes then done.
- rst_n low during the 3rd accept cycle -> bank_we=0 asynchronously; after release, state is IDLE, in_ready=0, and no write occurs.
